// File: rtl/ahb_interface.sv
// rtl/ahb_interface.sv - AHB-style slave wrapping a DEPTH x 32-bit register bank
//
// Ports:
//   hclk        bus clock; all state changes on its rising edge
//   hresetn     asynchronous active-low reset
//   haddr       byte address, sampled in the address phase
//   htrans      transfer type; htrans[1]=1 marks a valid transfer
//   hwrite      1 = write, 0 = read, sampled in the address phase
//   hwdata      write data, valid during the write data phase
//   hrdata      read data, driven during a read data phase, 0 otherwise
//   hready      1 = current data phase completes this cycle
//   xfer_count  count of completed transfers (wraps at 16 bits)
module ahb_interface #(
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [31:0] hwdata,
  output logic [31:0] hrdata,
  output logic        hready,
  output logic [15:0] xfer_count
);

  localparam int         AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0] WS = 3'(WAIT_STATES);

  logic [31:0]   mem [DEPTH];

  // Captured address phase; describes the data phase currently in progress.
  logic          pending;
  logic          pend_write;
  logic          pend_oor;
  logic [AW-1:0] pend_idx;
  logic [2:0]    wait_cnt;

  logic          addr_accept;
  logic          data_done;
  logic          addr_oor;
  logic [AW-1:0] addr_idx;
  logic          unused_lsbs;

  // Byte-lane bits carry no meaning: every transfer is a full word.
  assign unused_lsbs = ^haddr[1:0];

  always_comb begin
    hready      = !pending || (wait_cnt == WS);
    data_done   = pending && hready;
    // Address phase only samples while the previous data phase is finishing
    // (or idle), so the bus is ignored during inserted wait states.
    addr_accept = hready && htrans[1];
    addr_idx    = haddr[AW+1:2];
    addr_oor    = |haddr[31:AW+2];
    hrdata      = '0;
    if (pending && !pend_write && !pend_oor) begin
      hrdata = mem[pend_idx];
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      pending    <= 1'b0;
      pend_write <= 1'b0;
      pend_oor   <= 1'b0;
      pend_idx   <= '0;
      wait_cnt   <= '0;
      xfer_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      // The write commits on the same edge that may accept the next address
      // phase, so a following read of the same word already sees new data.
      if (data_done) begin
        xfer_count <= xfer_count + 16'd1;
        if (pend_write && !pend_oor) begin
          mem[pend_idx] <= hwdata;
        end
      end

      if (addr_accept) begin
        pending    <= 1'b1;
        pend_write <= hwrite;
        pend_idx   <= addr_idx;
        pend_oor   <= addr_oor;
        wait_cnt   <= '0;
      end else if (data_done) begin
        pending  <= 1'b0;
        wait_cnt <= '0;
      end else if (pending) begin
        wait_cnt <= wait_cnt + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_ahb_interface.sv
// tb/tb_ahb_interface.sv - directed self-checking bench for ahb_interface
module tb_ahb_interface;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] BUSY   = 2'b01;
  localparam logic [1:0] NONSEQ = 2'b10;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [31:0] hwdata;

  logic [31:0] rd0, rd2, rd3;
  logic        rdy0, rdy2, rdy3;
  logic [15:0] cnt0, cnt2, cnt3;

  int total  = 0;
  int passed = 0;

  always #5 hclk = ~hclk;

  ahb_interface #(.DEPTH(16), .WAIT_STATES(0)) u0 (
    .hclk(hclk), .hresetn(hresetn), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hwdata(hwdata), .hrdata(rd0), .hready(rdy0),
    .xfer_count(cnt0)
  );

  ahb_interface #(.DEPTH(16), .WAIT_STATES(2)) u2 (
    .hclk(hclk), .hresetn(hresetn), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hwdata(hwdata), .hrdata(rd2), .hready(rdy2),
    .xfer_count(cnt2)
  );

  ahb_interface #(.DEPTH(16), .WAIT_STATES(3)) u3 (
    .hclk(hclk), .hresetn(hresetn), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hwdata(hwdata), .hrdata(rd3), .hready(rdy3),
    .xfer_count(cnt3)
  );

  task automatic cyc();
    @(posedge hclk);
    @(negedge hclk);
  endtask

  task automatic drive(input logic [1:0] t, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    htrans = t;
    hwrite = w;
    haddr  = a;
    hwdata = d;
  endtask

  task automatic do_reset();
    drive(IDLE, 1'b0, 32'h0, 32'h0);
    hresetn = 1'b0;
    cyc();
    cyc();
    hresetn = 1'b1;
  endtask

  task automatic test_reset();
    drive(IDLE, 1'b0, 32'h0, 32'h0);
    hresetn = 1'b0;
    cyc();
    cyc();
    total++; if (rdy0 !== 1'b1) $display("FAIL reset_hready: got %b want 1", rdy0); else passed++;
    total++; if (rd0 !== 32'h0) $display("FAIL reset_hrdata: got %h want 00000000", rd0); else passed++;
    total++; if (cnt0 !== 16'h0) $display("FAIL reset_count: got %h want 0000", cnt0); else passed++;
    total++; if (rdy3 !== 1'b1) $display("FAIL reset_hready_ws3: got %b want 1", rdy3); else passed++;
    total++; if (cnt2 !== 16'h0) $display("FAIL reset_count_ws2: got %h want 0000", cnt2); else passed++;
  endtask

  // Address phase presented on the first edge after reset release.
  task automatic test_read_after_reset();
    drive(NONSEQ, 1'b0, 32'h0, 32'h0);
    hresetn = 1'b1;
    cyc();
    drive(IDLE, 1'b0, 32'h0, 32'h0);
    total++; if (rdy0 !== 1'b1) $display("FAIL first_read_hready: got %b want 1", rdy0); else passed++;
    total++; if (rd0 !== 32'h0) $display("FAIL first_read_data: got %h want 00000000", rd0); else passed++;
    cyc();
    total++; if (cnt0 !== 16'd1) $display("FAIL first_read_count: got %0d want 1", cnt0); else passed++;
    total++; if (rdy0 !== 1'b1) $display("FAIL first_read_idle_hready: got %b want 1", rdy0); else passed++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(NONSEQ, 1'b1, 32'h4, 32'h0);
    cyc();
    drive(NONSEQ, 1'b0, 32'h4, 32'hDEADBEEF);
    total++; if (rdy0 !== 1'b1) $display("FAIL b2b_write_hready: got %b want 1", rdy0); else passed++;
    total++; if (rd0 !== 32'h0) $display("FAIL b2b_write_hrdata: got %h want 00000000", rd0); else passed++;
    cyc();
    total++; if (rd0 !== 32'hDEADBEEF) $display("FAIL b2b_raw_data: got %h want deadbeef", rd0); else passed++;
    total++; if (rdy0 !== 1'b1) $display("FAIL b2b_read_hready: got %b want 1", rdy0); else passed++;
    drive(IDLE, 1'b0, 32'h0, 32'h0);
    cyc();
    total++; if (cnt0 !== 16'd2) $display("FAIL b2b_count: got %0d want 2", cnt0); else passed++;
    total++; if (rd0 !== 32'h0) $display("FAIL b2b_idle_hrdata: got %h want 00000000", rd0); else passed++;
  endtask

  task automatic test_out_of_range();
    do_reset();
    drive(NONSEQ, 1'b1, 32'h0, 32'h0);
    cyc();
    drive(NONSEQ, 1'b1, 32'h100, 32'h11112222);
    cyc();
    drive(NONSEQ, 1'b0, 32'h100, 32'hFFFFFFFF);
    cyc();
    total++; if (rd0 !== 32'h0) $display("FAIL oor_read_data: got %h want 00000000", rd0); else passed++;
    total++; if (rdy0 !== 1'b1) $display("FAIL oor_read_hready: got %b want 1", rdy0); else passed++;
    drive(NONSEQ, 1'b0, 32'h0, 32'h0);
    cyc();
    total++; if (rd0 !== 32'h11112222) $display("FAIL oor_alias_word0: got %h want 11112222", rd0); else passed++;
    drive(IDLE, 1'b0, 32'h0, 32'h0);
    cyc();
    total++; if (cnt0 !== 16'd4) $display("FAIL oor_count: got %0d want 4", cnt0); else passed++;
  endtask

  task automatic test_wait_states();
    do_reset();
    drive(NONSEQ, 1'b1, 32'h8, 32'h0);
    cyc();
    // Bus garbage during wait states must be ignored.
    drive(NONSEQ, 1'b0, 32'hC, 32'h12345678);
    total++; if (rdy2 !== 1'b0) $display("FAIL ws_wait1_hready: got %b want 0", rdy2); else passed++;
    total++; if (u2.mem[2] !== 32'h0) $display("FAIL ws_wait1_mem: got %h want 00000000", u2.mem[2]); else passed++;
    cyc();
    total++; if (rdy2 !== 1'b0) $display("FAIL ws_wait2_hready: got %b want 0", rdy2); else passed++;
    cyc();
    drive(IDLE, 1'b0, 32'h0, 32'h12345678);
    total++; if (rdy2 !== 1'b1) $display("FAIL ws_final_hready: got %b want 1", rdy2); else passed++;
    total++; if (u2.mem[2] !== 32'h0) $display("FAIL ws_final_mem_early: got %h want 00000000", u2.mem[2]); else passed++;
    cyc();
    total++; if (u2.mem[2] !== 32'h12345678) $display("FAIL ws_mem_commit: got %h want 12345678", u2.mem[2]); else passed++;
    total++; if (cnt2 !== 16'd1) $display("FAIL ws_write_count: got %0d want 1", cnt2); else passed++;
    total++; if (rdy2 !== 1'b1) $display("FAIL ws_no_ghost_xfer: got %b want 1", rdy2); else passed++;
    drive(NONSEQ, 1'b0, 32'h8, 32'h0);
    cyc();
    drive(IDLE, 1'b0, 32'h0, 32'h0);
    total++; if (rdy2 !== 1'b0) $display("FAIL ws_read_wait_hready: got %b want 0", rdy2); else passed++;
    cyc();
    cyc();
    total++; if (rdy2 !== 1'b1) $display("FAIL ws_read_final_hready: got %b want 1", rdy2); else passed++;
    total++; if (rd2 !== 32'h12345678) $display("FAIL ws_read_data: got %h want 12345678", rd2); else passed++;
    cyc();
    total++; if (cnt2 !== 16'd2) $display("FAIL ws_read_count: got %0d want 2", cnt2); else passed++;
  endtask

  task automatic test_idle();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive((i % 2 == 0) ? IDLE : BUSY, 1'b1, 32'h4, 32'hA5A5A5A5);
      cyc();
      total++; if (rdy0 !== 1'b1) $display("FAIL idle_hready_%0d: got %b want 1", i, rdy0); else passed++;
    end
    total++; if (cnt0 !== 16'd0) $display("FAIL idle_count: got %0d want 0", cnt0); else passed++;
    total++; if (u0.mem[1] !== 32'h0) $display("FAIL idle_no_write: got %h want 00000000", u0.mem[1]); else passed++;
  endtask

  task automatic test_count_wrap();
    do_reset();
    drive(NONSEQ, 1'b0, 32'h0, 32'h0);
    repeat (65535) cyc();
    drive(IDLE, 1'b0, 32'h0, 32'h0);
    cyc();
    total++; if (cnt0 !== 16'hFFFF) $display("FAIL wrap_max: got %h want ffff", cnt0); else passed++;
    drive(NONSEQ, 1'b0, 32'h0, 32'h0);
    cyc();
    drive(IDLE, 1'b0, 32'h0, 32'h0);
    cyc();
    total++; if (cnt0 !== 16'h0) $display("FAIL wrap_zero: got %h want 0000", cnt0); else passed++;
  endtask

  task automatic test_reset_mid_phase();
    int n;
    do_reset();
    drive(NONSEQ, 1'b1, 32'h0, 32'h0);
    cyc();
    drive(IDLE, 1'b0, 32'h0, 32'hCAFEF00D);
    total++; if (rdy3 !== 1'b0) $display("FAIL midrst_wait_hready: got %b want 0", rdy3); else passed++;
    cyc();
    cyc();
    total++; if (rdy3 !== 1'b0) $display("FAIL midrst_wait3_hready: got %b want 0", rdy3); else passed++;
    hresetn = 1'b0;
    #1;
    total++; if (rdy3 !== 1'b1) $display("FAIL midrst_hready: got %b want 1", rdy3); else passed++;
    total++; if (cnt3 !== 16'd0) $display("FAIL midrst_count: got %0d want 0", cnt3); else passed++;
    @(negedge hclk);
    cyc();
    hresetn = 1'b1;
    drive(NONSEQ, 1'b0, 32'h0, 32'h0);
    cyc();
    drive(IDLE, 1'b0, 32'h0, 32'h0);
    n = 0;
    while (rdy3 !== 1'b1 && n < 8) begin
      cyc();
      n++;
    end
    total++; if (rdy3 !== 1'b1) $display("FAIL midrst_read_timeout: got hready %b want 1", rdy3); else passed++;
    total++; if (n !== 3) $display("FAIL midrst_read_waits: got %0d want 3", n); else passed++;
    total++; if (rd3 !== 32'h0) $display("FAIL midrst_word_kept_zero: got %h want 00000000", rd3); else passed++;
    cyc();
    total++; if (cnt3 !== 16'd1) $display("FAIL midrst_read_count: got %0d want 1", cnt3); else passed++;
  endtask

  initial begin
    hresetn = 1'b0;
    drive(IDLE, 1'b0, 32'h0, 32'h0);
    @(negedge hclk);
    test_reset();
    test_read_after_reset();
    test_back_to_back();
    test_out_of_range();
    test_wait_states();
    test_idle();
    test_reset_mid_phase();
    test_count_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ahb_interface.md
AHB_INTERFACE -- requirements
Module: ahb_interface

Interface
REQ-001 SHALL have parameter DEPTH, default 16; number of 32-bit words in the register bank; power of two, 2..256.
REQ-002 SHALL have parameter WAIT_STATES, default 0; number of hready-low cycles inserted at the start of every data phase; 0..7.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port hclk, input, 1 bit: bus clock; all state changes on its rising edge.
REQ-005 SHALL have port hresetn, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port haddr, input, 32 bits: byte address, sampled in the address phase.
REQ-007 SHALL have port htrans, input, 2 bits: transfer type. htrans[1]=1 (NONSEQ/SEQ) marks a valid transfer; IDLE and BUSY mark no transfer.
REQ-008 SHALL have port hwrite, input, 1 bit: 1 = write, 0 = read, sampled in the address phase.
REQ-009 SHALL have port hwdata, input, 32 bits: write data, valid during the write data phase.
REQ-010 SHALL have port hrdata, output, 32 bits: read data, valid during the read data phase when hready=1.
REQ-011 SHALL have port hready, output, 1 bit: 1 = current data phase completes this cycle.
REQ-012 SHALL have port xfer_count, output, 16 bits: number of completed transfers, reads and writes combined.

Function
REQ-013 SHALL accept an address phase only on a rising edge where hready=1 and htrans[1]=1; at that edge it registers haddr, hwrite and a pending flag.
REQ-014 SHALL use word index haddr[log2(DEPTH)+1:2]; haddr[1:0] ignored; all transfers are 32-bit.
REQ-015 SHALL treat an address as out of range when haddr[31:log2(DEPTH)+2] is nonzero: writes to it are dropped, reads from it return 0, and it still completes normally (no error response).
REQ-016 SHALL hold hready=0 for exactly WAIT_STATES cycles at the start of each data phase, then drive hready=1 for one cycle, which completes the transfer.
REQ-017 SHALL drive hready=1 whenever no data phase is pending.
REQ-018 SHALL write hwdata into the addressed word on the rising edge that ends a write data phase (hready=1).
REQ-019 SHALL drive hrdata combinationally from the addressed word during a read data phase, and drive hrdata=0 at all other times.
REQ-020 SHALL support back-to-back transfers: a new address phase may overlap the completing data phase (pipelined), giving zero idle cycles when WAIT_STATES=0.
REQ-021 SHALL return the new value to a read whose address phase overlaps the data phase of a write to the same word, with no stall, because the write commits before the read data phase begins.
REQ-022 SHALL ignore haddr, htrans and hwrite while hready=0.
REQ-023 SHALL increment xfer_count by 1 on every completed data phase, wrapping from 0xFFFF to 0x0000.

Reset
REQ-024 SHALL, while hresetn=0, clear all DEPTH words to 0, clear the pending flag and wait counter, and set xfer_count=0, hready=1, hrdata=0.
REQ-025 SHALL abandon a data phase in progress when reset is asserted: no write commits and xfer_count stays 0.
REQ-026 SHALL accept a new address phase on the first rising edge after hresetn deasserts.

Verification
REQ-027 Reset, then a read of 0x0 with WAIT_STATES=0 -> hrdata=0x00000000 with hready=1 in the data phase; xfer_count=1.
REQ-028 Write 0xDEADBEEF to 0x4, then immediately read 0x4 -> read data phase shows hrdata=0xDEADBEEF; xfer_count=2.
REQ-029 WAIT_STATES=2, write 0x12345678 to 0x8 -> hready low for 2 cycles then high for 1; memory updated only on the final edge; later read returns 0x12345678.
REQ-030 Write 0xFFFFFFFF to 0x100 with DEPTH=16 -> write dropped; read of 0x100 returns 0; read of 0x0 unchanged; both transfers counted.
REQ-031 IDLE cycles with htrans=00 -> no count change and hready stays 1; 65536 completed transfers -> xfer_count wraps to 0.
REQ-032 Assert hresetn=0 during a write data phase with WAIT_STATES=3 -> the target word stays 0, hready=1, and xfer_count=0 immediately.
